// File: rtl/pic_gw_pkg.sv
// Shared definitions for the PIC interrupt gateway: per-source FSM
// state encoding and the reserved "no interrupt" source ID.
package pic_gw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PEND    = 2'b01,
      ST_CLAIMED = 2'b10
   } gw_state_e;

   localparam int ID_RSVD = 0;

endpackage

// File: rtl/pic_gateway_cell.sv
// One interrupt source of the gateway: synchroniser, edge detect,
// claim/complete FSM and saturating pending-edge counter.
// Ports:
//   pic_clk, pic_rst  clock, async active-high reset
//   src_i             raw async source
//   edge_i, en_i      mode (1=edge) and enable
//   claim_i, cmplt_i  decoded one-hot strobes for this source
//   pend_o, active_o  pending / in-service flags (from state register)
//   ovf_o             one-cycle pulse when an edge is dropped at saturation
module pic_gateway_cell
   import pic_gw_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 3
) (
   input  logic pic_clk,
   input  logic pic_rst,
   input  logic src_i,
   input  logic edge_i,
   input  logic en_i,
   input  logic claim_i,
   input  logic cmplt_i,
   output logic pend_o,
   output logic active_o,
   output logic ovf_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   edge_q;
   gw_state_e              state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;

   logic sync_w;
   logic req_edge;
   logic req;
   logic inc;
   logic dec;
   logic mode_chg;

   assign sync_w   = sync_q[SYNC_STAGES-1];
   assign req_edge = sync_w & ~dly_q;
   assign req      = edge_i ? req_edge : sync_w;
   assign mode_chg = edge_i ^ edge_q;

   always_ff @(posedge pic_clk or posedge pic_rst) begin
      if (pic_rst) begin
         sync_q  <= '0;
         dly_q   <= 1'b0;
         edge_q  <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], src_i};
         dly_q   <= sync_w;
         edge_q  <= edge_i;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = 1'b0;
      dec     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (en_i && req) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (!en_i)        state_d = ST_IDLE;
            else if (claim_i) state_d = ST_CLAIMED;
         end
         ST_CLAIMED: begin
            // Queued edges re-arm the source directly on completion.
            if (cmplt_i) begin
               if (edge_i && en_i && (cnt_q != '0)) begin
                  state_d = ST_PEND;
                  dec     = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Edges arriving while pending or in service are queued.
      inc = en_i && edge_i && req_edge && (state_q != ST_IDLE);

      if (!en_i || mode_chg) begin
         cnt_d = '0;
      end else if (inc && !dec) begin
         if (cnt_q == CNT_MAX) ovf_d = 1'b1;
         else                  cnt_d = cnt_q + 1'b1;
      end else if (dec && !inc) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign pend_o   = (state_q == ST_PEND);
   assign active_o = (state_q == ST_CLAIMED);
   assign ovf_o    = ovf_q;

endmodule

// File: rtl/pic_int_gateway.sv
// PIC input gateway: per-source level/edge qualification with a
// claim/complete handshake. ID 0 is reserved and never pends.
// Ports:
//   pic_clk, pic_rst            clock, async active-high reset
//   int_src_i                   raw async sources (bit 0 ignored)
//   cfg_edge_i, cfg_en_i        per-source mode and enable
//   claim_vld_i, claim_id_i     claim pulse and source ID
//   cmplt_vld_i, cmplt_id_i     completion pulse and source ID
//   pend_o, active_o            pending / in-service vectors (bit 0 = 0)
//   cnt_ovf_o                   pulse: an edge was dropped at saturation
module pic_int_gateway
   import pic_gw_pkg::*;
#(
   parameter int NUM_SRC     = 32,
   parameter int ID_W        = $clog2(NUM_SRC),
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 3
) (
   input  logic               pic_clk,
   input  logic               pic_rst,
   input  logic [NUM_SRC-1:0] int_src_i,
   input  logic [NUM_SRC-1:0] cfg_edge_i,
   input  logic [NUM_SRC-1:0] cfg_en_i,
   input  logic               claim_vld_i,
   input  logic [ID_W-1:0]    claim_id_i,
   input  logic               cmplt_vld_i,
   input  logic [ID_W-1:0]    cmplt_id_i,
   output logic [NUM_SRC-1:0] pend_o,
   output logic [NUM_SRC-1:0] active_o,
   output logic               cnt_ovf_o
);

   logic [NUM_SRC-1:0] claim_oh;
   logic [NUM_SRC-1:0] cmplt_oh;
   logic [NUM_SRC-1:0] pend_w;
   logic [NUM_SRC-1:0] act_w;
   logic [NUM_SRC-1:0] ovf_w;
   logic               unused_w;

   // IDs that match no cell (reserved or out of range) decode to nothing.
   always_comb begin
      claim_oh = '0;
      cmplt_oh = '0;
      for (int n = 0; n < NUM_SRC; n++) begin
         if (n != ID_RSVD) begin
            claim_oh[n] = claim_vld_i && (int'(claim_id_i) == n);
            cmplt_oh[n] = cmplt_vld_i && (int'(cmplt_id_i) == n);
         end
      end
   end

   assign pend_w[ID_RSVD] = 1'b0;
   assign act_w[ID_RSVD]  = 1'b0;
   assign ovf_w[ID_RSVD]  = 1'b0;

   for (genvar n = 1; n < NUM_SRC; n++) begin : g_cell
      pic_gateway_cell #(
         .SYNC_STAGES(SYNC_STAGES),
         .CNT_W      (CNT_W)
      ) u_cell (
         .pic_clk (pic_clk),
         .pic_rst (pic_rst),
         .src_i   (int_src_i[n]),
         .edge_i  (cfg_edge_i[n]),
         .en_i    (cfg_en_i[n]),
         .claim_i (claim_oh[n]),
         .cmplt_i (cmplt_oh[n]),
         .pend_o  (pend_w[n]),
         .active_o(act_w[n]),
         .ovf_o   (ovf_w[n])
      );
   end

   assign pend_o    = pend_w;
   assign active_o  = act_w;
   assign cnt_ovf_o = |ovf_w;

   assign unused_w = ^{int_src_i[ID_RSVD], cfg_edge_i[ID_RSVD],
                       cfg_en_i[ID_RSVD], claim_oh[ID_RSVD],
                       cmplt_oh[ID_RSVD]};

endmodule

// File: tb/tb_pic_int_gateway.sv
// Self-checking bench for pic_int_gateway: directed scenarios plus a
// randomized phase, all compared against a behavioural model.
module tb_pic_int_gateway;

   localparam int N    = 32;
   localparam int SS   = 2;
   localparam int IDW  = 5;
   localparam int CMAX = 7;

   logic           pic_clk;
   logic           pic_rst;
   logic [N-1:0]   int_src_i;
   logic [N-1:0]   cfg_edge_i;
   logic [N-1:0]   cfg_en_i;
   logic           claim_vld_i;
   logic [IDW-1:0] claim_id_i;
   logic           cmplt_vld_i;
   logic [IDW-1:0] cmplt_id_i;
   logic [N-1:0]   pend_o;
   logic [N-1:0]   active_o;
   logic           cnt_ovf_o;

   pic_int_gateway #(
      .NUM_SRC    (N),
      .ID_W       (IDW),
      .SYNC_STAGES(SS),
      .CNT_W      (3)
   ) dut (
      .pic_clk    (pic_clk),
      .pic_rst    (pic_rst),
      .int_src_i  (int_src_i),
      .cfg_edge_i (cfg_edge_i),
      .cfg_en_i   (cfg_en_i),
      .claim_vld_i(claim_vld_i),
      .claim_id_i (claim_id_i),
      .cmplt_vld_i(cmplt_vld_i),
      .cmplt_id_i (cmplt_id_i),
      .pend_o     (pend_o),
      .active_o   (active_o),
      .cnt_ovf_o  (cnt_ovf_o)
   );

   initial pic_clk = 1'b0;
   always #5 pic_clk = ~pic_clk;

   int n_chk  = 0;
   int n_fail = 0;
   int ovf_seen = 0;

   // Model: delay line of sampled inputs, plus per-source state
   // (0 idle, 1 pending, 2 in service) and queued-edge count.
   logic [N-1:0] h [SS+2];
   int           mst  [N];
   int           mcnt [N];
   bit           mprev[N];
   logic [N-1:0] m_pend;
   logic [N-1:0] m_act;
   logic         m_ovf;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < SS + 2; i++) h[i] = '0;
      for (int n = 0; n < N; n++) begin
         mst[n] = 0; mcnt[n] = 0; mprev[n] = 1'b0;
      end
      m_pend = '0; m_act = '0; m_ovf = 1'b0;
   endtask

   task automatic model_step();
      if (pic_rst) begin
         model_reset();
         return;
      end
      for (int i = SS + 1; i > 0; i--) h[i] = h[i-1];
      h[0]  = int_src_i;
      m_ovf = 1'b0;
      for (int n = 1; n < N; n++) begin
         bit s, d, ev, ed, en, req, chg, clm, cmp;
         int old, took, c;
         s   = h[SS][n];
         d   = h[SS+1][n];
         ev  = s && !d;
         ed  = cfg_edge_i[n];
         en  = cfg_en_i[n];
         req = ed ? ev : s;
         chg = (ed != mprev[n]);
         mprev[n] = ed;
         clm = claim_vld_i && (int'(claim_id_i) == n);
         cmp = cmplt_vld_i && (int'(cmplt_id_i) == n);
         old  = mst[n];
         took = 0;
         case (old)
            0: if (en && req) mst[n] = 1;
            1: if (!en) mst[n] = 0; else if (clm) mst[n] = 2;
            default:
               if (cmp) begin
                  if (ed && en && mcnt[n] > 0) begin
                     mst[n] = 1; took = 1;
                  end else mst[n] = 0;
               end
         endcase
         if (!en || chg) mcnt[n] = 0;
         else begin
            c = mcnt[n] + ((ed && ev && old != 0) ? 1 : 0) - took;
            if (c > CMAX) begin c = CMAX; m_ovf = 1'b1; end
            mcnt[n] = c;
         end
      end
      for (int n = 0; n < N; n++) begin
         m_pend[n] = (mst[n] == 1);
         m_act[n]  = (mst[n] == 2);
      end
   endtask

   task automatic cyc();
      @(posedge pic_clk);
      #1;
      model_step();
      check("pend_o", pend_o, m_pend);
      check("active_o", active_o, m_act);
      check("cnt_ovf_o", 32'(cnt_ovf_o), 32'(m_ovf));
      if (cnt_ovf_o) ovf_seen++;
   endtask

   task automatic claim(input int id);
      claim_vld_i = 1'b1; claim_id_i = IDW'(id);
      cyc();
      claim_vld_i = 1'b0;
   endtask

   task automatic cmplt(input int id);
      cmplt_vld_i = 1'b1; cmplt_id_i = IDW'(id);
      cyc();
      cmplt_vld_i = 1'b0;
   endtask

   task automatic pulse(input int n);
      int_src_i[n] = 1'b1; cyc();
      int_src_i[n] = 1'b0; cyc(); cyc();
   endtask

   task automatic wait_pend(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (pend_o[n]) begin ok = 1'b1; return; end
         cyc();
      end
      ok = pend_o[n];
   endtask

   task automatic do_reset();
      int_src_i = '0; cfg_edge_i = '0; cfg_en_i = '0;
      claim_vld_i = 1'b0; cmplt_vld_i = 1'b0;
      pic_rst = 1'b1;
      cyc(); cyc();
      pic_rst = 1'b0;
      cyc();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      int cnt, ovf0;
      int_src_i = '0; cfg_edge_i = '0; cfg_en_i = '0;
      claim_vld_i = 1'b0; claim_id_i = '0;
      cmplt_vld_i = 1'b0; cmplt_id_i = '0;
      pic_rst = 1'b1;
      model_reset();
      cyc(); cyc();
      check("rst_pend", pend_o, 0);
      check("rst_act", active_o, 0);
      pic_rst = 1'b0;
      cyc();

      // Level source: latency, claim, complete with level held high
      cfg_en_i[3] = 1'b1; int_src_i[3] = 1'b1;
      cyc(); cyc();
      check("lat_early", 32'(pend_o[3]), 0);
      cyc();
      check("lat_pend", 32'(pend_o[3]), 1);
      claim(3);
      check("lvl_claim_pend", 32'(pend_o[3]), 0);
      check("lvl_claim_act", 32'(active_o[3]), 1);
      cmplt(3);
      check("lvl_cmplt_pend", 32'(pend_o[3]), 0);
      cyc();
      check("lvl_repend", 32'(pend_o[3]), 1);
      do_reset();

      // Edge burst: four edges queued while in service
      cfg_en_i[5] = 1'b1; cfg_edge_i[5] = 1'b1;
      pulse(5);
      wait_pend(5, ok);
      check("burst_first", 32'(ok), 1);
      claim(5);
      repeat (4) pulse(5);
      cnt = 1;
      for (int k = 0; k < 10; k++) begin
         cmplt(5);
         wait_pend(5, ok);
         if (!ok) break;
         claim(5);
         cnt++;
      end
      check("burst_claims", cnt, 5);
      do_reset();

      // Saturation: one edge to pend, eight more while in service
      cfg_en_i[6] = 1'b1; cfg_edge_i[6] = 1'b1;
      pulse(6);
      wait_pend(6, ok);
      claim(6);
      ovf0 = ovf_seen;
      repeat (8) pulse(6);
      check("sat_ovf", ovf_seen - ovf0, 1);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
         cmplt(6);
         cnt++;
         wait_pend(6, ok);
         if (!ok) break;
         claim(6);
      end
      check("sat_cmplts", cnt, 8);
      do_reset();

      // Simultaneous claim/complete and ignored requests
      cfg_en_i[7] = 1'b1; int_src_i[7] = 1'b1;
      cfg_en_i[5] = 1'b1; cfg_edge_i[5] = 1'b1;
      pulse(5);
      wait_pend(5, ok);
      claim(5);
      cmplt_vld_i = 1'b1; cmplt_id_i = 5'd5;
      claim_vld_i = 1'b1; claim_id_i = 5'd7;
      cyc();
      cmplt_vld_i = 1'b0; claim_vld_i = 1'b0;
      check("sim_act7", 32'(active_o[7]), 1);
      check("sim_act5", 32'(active_o[5]), 0);
      claim(0);
      claim(8);
      cfg_en_i[9] = 1'b1; int_src_i[9] = 1'b1;
      wait_pend(9, ok);
      cmplt(9);
      check("cmplt_pend_ign", 32'(pend_o[9]), 1);
      check("cmplt_act_ign", 32'(active_o[9]), 0);
      do_reset();

      // Disable while pending; edge while disabled is discarded
      cfg_en_i[10] = 1'b1; int_src_i[10] = 1'b1;
      wait_pend(10, ok);
      cfg_en_i[10] = 1'b0;
      cyc();
      check("dis_pend", 32'(pend_o[10]), 0);
      int_src_i[10] = 1'b0;
      cfg_edge_i[11] = 1'b1;
      pulse(11);
      cfg_en_i[11] = 1'b1;
      repeat (5) cyc();
      check("dis_edge", 32'(pend_o[11]), 0);
      do_reset();

      // Async reset mid-handshake
      cfg_en_i[2] = 1'b1; cfg_edge_i[2] = 1'b1;
      pulse(2);
      wait_pend(2, ok);
      claim(2);
      repeat (3) pulse(2);
      #2;
      pic_rst = 1'b1;
      #1;
      check("arst_pend", pend_o, 0);
      check("arst_act", active_o, 0);
      check("arst_ovf", 32'(cnt_ovf_o), 0);
      model_reset();
      cyc();
      pic_rst = 1'b0;
      cyc();
      cmplt(2);
      check("arst_cmplt", 32'(active_o[2]), 0);
      do_reset();

      // Randomized traffic on the low sources
      cfg_edge_i = N'($urandom);
      cfg_en_i   = '1;
      for (int k = 0; k < 800; k++) begin
         int_src_i = int_src_i ^ (N'($urandom) & N'($urandom) &
                                  N'($urandom) & 32'h0000_0ffe);
         if ($urandom_range(0, 49) == 0)
            cfg_edge_i[$urandom_range(1, 11)] ^= 1'b1;
         if ($urandom_range(0, 39) == 0)
            cfg_en_i[$urandom_range(1, 11)] ^= 1'b1;
         claim_vld_i = ($urandom_range(0, 2) == 0);
         claim_id_i  = IDW'($urandom_range(0, 12));
         cmplt_vld_i = ($urandom_range(0, 2) == 0);
         cmplt_id_i  = IDW'($urandom_range(0, 12));
         pic_rst     = ($urandom_range(0, 299) == 0);
         cyc();
      end
      pic_rst = 1'b0;
      claim_vld_i = 1'b0;
      cmplt_vld_i = 1'b0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
